// File: rtl/awmc_pkg.sv
// Shared types for the washing machine controller: stage encodings, mode codes
// and the mode-to-wash-length mapping.
// Latency: n/a (package). Backpressure: n/a.
package awmc_pkg;

  // Stage encodings are visible on the stage output, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  localparam logic [1:0] MODE_QUICK  = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_HEAVY  = 2'd2;

  // Wash length in cycles for a mode; mode 3 falls back to normal.
  function automatic int unsigned wash_len(input logic [1:0] mode,
                                           input int unsigned wash_ticks);
    case (mode)
      MODE_QUICK: return wash_ticks >> 1;
      MODE_HEAVY: return wash_ticks << 1;
      default:    return wash_ticks;
    endcase
  endfunction

endpackage

// File: rtl/awmc_timer.sv
// Loadable stage down-counter; load wins over decrement, count stops at zero.
// Latency: load/decrement visible one cycle after the edge; zero_o is combinational from the count.
// Backpressure: en_i low freezes the count (used for pause / lid-open hold).
//   clk, rst_n_i        : clock, async active-low reset (count clears to 0)
//   load_i, load_val_i  : load a new count on the next edge
//   en_i                : decrement enable
//   zero_o              : count is zero
module awmc_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/awmc_prog.sv
// Mode-programmable washing machine controller: fill, wash, N rinse rounds, drain, spin.
// Latency: every output is registered and changes on the edge that enters the state it describes.
// Backpressure: pause=1 or lid=0 holds the active stage in place with actuators off.
//   clk, reset          : clock, async active-low reset
//   start, pause, lid   : front panel (start level-sampled, lid 1 = closed)
//   level_full          : water level sensor
//   mode, rinse_cnt     : program selection, latched at start
//   stage               : current state encoding
//   done, fault         : cycle complete / sticky fill-timeout fault
//   input_valve, output_drain, motor, spin : actuator drives
module awmc_prog
  import awmc_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned WASH_TICKS   = 20,
  parameter int unsigned RINSE_TICKS  = 10,
  parameter int unsigned DRAIN_TICKS  = 6,
  parameter int unsigned SPIN_TICKS   = 12,
  parameter int unsigned FILL_TIMEOUT = 30,
  parameter int unsigned MAX_RINSE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       lid,
  input  logic       level_full,
  input  logic [1:0] mode,
  input  logic [1:0] rinse_cnt,
  output logic [2:0] stage,
  output logic       done,
  output logic       input_valve,
  output logic       output_drain,
  output logic       motor,
  output logic       spin,
  output logic       fault
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  // Reject durations that cannot be represented or that scale to zero.
  if ((WASH_TICKS * 2) >= CNT_LIMIT || FILL_TIMEOUT >= CNT_LIMIT ||
      RINSE_TICKS >= CNT_LIMIT || DRAIN_TICKS >= CNT_LIMIT ||
      SPIN_TICKS >= CNT_LIMIT) begin : g_bad_width
    $error("awmc_prog: a duration does not fit in CNT_W bits");
  end
  if ((WASH_TICKS >> 1) < 1 || FILL_TIMEOUT < 1 || RINSE_TICKS < 1 ||
      DRAIN_TICKS < 1 || SPIN_TICKS < 1) begin : g_bad_min
    $error("awmc_prog: every duration must be at least one cycle");
  end
  if (MAX_RINSE > 3) begin : g_bad_rinse
    $error("awmc_prog: MAX_RINSE must fit the 2-bit rinse counter");
  end

  // Timer reload values are duration-1 so a stage lasts exactly duration cycles.
  localparam logic [CNT_W-1:0] FILL_LD   = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RINSE_LD  = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_LD   = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0] WASH_Q_LD = CNT_W'(wash_len(MODE_QUICK, WASH_TICKS) - 1);
  localparam logic [CNT_W-1:0] WASH_N_LD = CNT_W'(wash_len(MODE_NORMAL, WASH_TICKS) - 1);
  localparam logic [CNT_W-1:0] WASH_H_LD = CNT_W'(wash_len(MODE_HEAVY, WASH_TICKS) - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RINSE);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       rinses_q, rinses_d;
  logic             phase_q, phase_d;   // 0 = wash fill, 1 = rinse fill
  logic             valve_q, drain_q, motor_q, spin_q, done_q, fault_q;
  logic             valve_d, drain_d, motor_d, spin_d, done_d, fault_d;

  logic             active;
  logic             hold_req;
  logic             hold;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  assign active   = (state_q == ST_FILL) || (state_q == ST_WASH) ||
                    (state_q == ST_RINSE) || (state_q == ST_DRAIN) ||
                    (state_q == ST_SPIN);
  assign hold_req = pause | ~lid;
  assign hold     = active & hold_req;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rinses_d = rinses_q;
    phase_d  = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && lid) begin
          state_d  = ST_FILL;
          mode_d   = mode;
          rinses_d = (rinse_cnt > MAX_R) ? MAX_R : rinse_cnt;
          phase_d  = 1'b0;
        end
      end
      ST_FILL: begin
        // A full drum wins over a timeout on the same edge.
        if (!hold) begin
          if (level_full) begin
            state_d = phase_q ? ST_RINSE : ST_WASH;
          end else if (tmr_zero) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_WASH, ST_RINSE: begin
        if (!hold && tmr_zero) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!hold && tmr_zero) begin
          if (rinses_q != 2'd0) begin
            rinses_d = rinses_q - 2'd1;
            phase_d  = 1'b1;
            state_d  = ST_FILL;
          end else begin
            state_d = ST_SPIN;
          end
        end
      end
      ST_SPIN: begin
        if (!hold && tmr_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload the timer on every state entry with the new stage's length.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_FILL:  tmr_val = FILL_LD;
      ST_WASH: begin
        case (mode_d)
          MODE_QUICK: tmr_val = WASH_Q_LD;
          MODE_HEAVY: tmr_val = WASH_H_LD;
          default:    tmr_val = WASH_N_LD;
        endcase
      end
      ST_RINSE: tmr_val = RINSE_LD;
      ST_DRAIN: tmr_val = DRAIN_LD;
      ST_SPIN:  tmr_val = SPIN_LD;
      default:  tmr_val = '0;
    endcase
  end

  // Actuators follow the next state but are gated by the hold inputs sampled now.
  always_comb begin
    valve_d = (state_d == ST_FILL) && !hold_req;
    motor_d = ((state_d == ST_WASH) || (state_d == ST_RINSE)) && !hold_req;
    drain_d = ((state_d == ST_DRAIN) || (state_d == ST_SPIN)) && !hold_req;
    spin_d  = (state_d == ST_SPIN) && !hold_req;
    done_d  = (state_d == ST_DONE);
    fault_d = (state_d == ST_FAULT);
  end

  awmc_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (!hold),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_QUICK;
      rinses_q <= 2'd0;
      phase_q  <= 1'b0;
      valve_q  <= 1'b0;
      drain_q  <= 1'b0;
      motor_q  <= 1'b0;
      spin_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rinses_q <= rinses_d;
      phase_q  <= phase_d;
      valve_q  <= valve_d;
      drain_q  <= drain_d;
      motor_q  <= motor_d;
      spin_q   <= spin_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign stage        = state_q;
  assign done         = done_q;
  assign input_valve  = valve_q;
  assign output_drain = drain_q;
  assign motor        = motor_q;
  assign spin         = spin_q;
  assign fault        = fault_q;

endmodule

// File: doc/awmc_prog.md
# awmc_prog

Parametrised, mode-programmable automatic washing machine controller: the next-generation AWMC. Sequences fill, wash, a programmable number of rinse rounds, drain and spin from a single start request. Per-stage durations come from parameters, and mode and rinse count are latched at start. Adds a water-level sensor with a fill-timeout fault, in-place pause/lid-open hold, and a sticky fault state. Sits between the front-panel/sensor inputs and the valve, drain and motor drivers.

## Interface
- `CNT_W`, 8, stage timer width in bits.
- `WASH_TICKS`, 20, normal-mode wash length in cycles.
- `RINSE_TICKS`, 10, length of one rinse agitation in cycles.
- `DRAIN_TICKS`, 6, length of one drain in cycles.
- `SPIN_TICKS`, 12, final spin length in cycles.
- `FILL_TIMEOUT`, 30, maximum number of FILL cycles before fault.
- `MAX_RINSE`, 3, ceiling applied to `rinse_cnt`.
- `clk  in  1`  system clock; rising edge.
- `reset  in  1`  one clock; reset is asynchronous and active-low.
- `start  in  1`  cycle request, level-sampled.
- `pause  in  1`  1 = hold the current stage.
- `lid  in  1`  1 = lid closed.
- `level_full  in  1`  water-level sensor, 1 = drum full.
- `mode  in  2`  0 = quick, 1 = normal, 2 = heavy, 3 = treated as normal.
- `rinse_cnt  in  2`  requested number of rinse rounds.
- `stage  out  3`  current state encoding.
- `done  out  1`  cycle complete.
- `input_valve  out  1`  water inlet open.
- `output_drain  out  1`  drain pump on.
- `motor  out  1`  drum agitation.
- `spin  out  1`  high-speed spin.
- `fault  out  1`  fill timeout occurred, sticky.

## Operation
- States and `stage` encodings: IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
- IDLE → FILL when `start`=1 and `lid`=1. On that edge:
  - latch `mode`;
  - latch `rinses_left` = min(`rinse_cnt`, `MAX_RINSE`);
  - clear the `phase` flag (0 = wash, 1 = rinse).
- FILL: `input_valve`=1. Exits when `level_full`=1 is sampled on an unheld cycle:
  - to WASH if `phase`=0;
  - to RINSE if `phase`=1.
- FILL timeout: after `FILL_TIMEOUT` unheld cycles without `level_full`, go to FAULT.
- WASH: `motor`=1 for the wash length, then DRAIN. Wash length by mode:
  - quick: `WASH_TICKS`>>1;
  - normal: `WASH_TICKS`;
  - heavy: `WASH_TICKS`<<1.
- RINSE: `motor`=1 for `RINSE_TICKS`, then DRAIN.
- DRAIN: `output_drain`=1 for `DRAIN_TICKS`, then:
  - if `rinses_left`>0: decrement `rinses_left`, set `phase`=1, go to FILL;
  - otherwise go to SPIN.
- SPIN: `spin`=1, `output_drain`=1 for `SPIN_TICKS`, then DONE.
- DONE: `done`=1. Returns to IDLE when `start`=0 is sampled, so a held `start` does not retrigger.
- FAULT: `fault`=1, all actuators off. Left only by `reset`.
- Hold condition: `pause`=1 or `lid`=0 in FILL, WASH, RINSE, DRAIN or SPIN.
  - The timer freezes; the state and `stage` are retained.
  - `input_valve`, `output_drain`, `motor` and `spin` are forced to 0.
  - Resumes with the remaining count when hold clears.
  - Hold has no effect in IDLE, DONE or FAULT.
- `start` is ignored outside IDLE. `mode` and `rinse_cnt` changes after start have no effect.
- Width rules:
  - all durations are loaded as `CNT_W`-bit values;
  - `WASH_TICKS`<<1, `FILL_TIMEOUT` and all other `*_TICKS` must fit in `CNT_W` bits; a violation is an elaboration error;
  - every duration must be ≥1 after scaling.

## Timing
- Reset values: `stage`=0, all other outputs 0, timer 0, `rinses_left` 0, `phase` 0.
- All outputs are registered and change on the same edge as the state they describe.
- Inputs sampled at edge N take effect at outputs after edge N.
- Timer behaviour:
  - loaded with duration−1 on the state-entry edge;
  - decrements on each unheld cycle;
  - the transition is taken on the unheld edge where the timer is 0.
- A timed stage therefore occupies exactly `duration` unheld cycles.
- FILL with `level_full` already high lasts 1 cycle.
- Simultaneous `level_full`=1 and timeout in FILL: the fill succeeds.
- Simultaneous hold and expiry: hold wins and the stage does not advance.
- Reset asserted mid-cycle: all outputs clear immediately (asynchronous).

## Structure
- Package `awmc_pkg`: state enum (3-bit, encodings above), mode constants, and a function returning the wash length for a given mode.
- Sub-module `awmc_timer`: `CNT_W`-bit loadable down-counter with `load`, `en` and `zero` signals.
- The FSM, latches and output registers stay in `awmc_prog`.

## Test plan
Parameters for all scenarios: `WASH_TICKS`=4, `RINSE_TICKS`=3, `DRAIN_TICKS`=2, `SPIN_TICKS`=5, `FILL_TIMEOUT`=8.

- Normal mode, `rinse_cnt`=1, `level_full` tied high → `stage` sequence 1,2×4,4×2,1,3×3,4×2,5×5,6. `done`=1 until `start` falls, then `stage`=0.
- Heavy mode, `rinse_cnt`=0 → WASH lasts 8 cycles. Quick mode → WASH lasts 2 cycles. `rinse_cnt`=3 with `MAX_RINSE`=2 → exactly 2 rinse rounds.
- `level_full` held low → FAULT after 8 FILL cycles, `fault`=1. `start` is ignored; only `reset` returns `stage` to 0.
- `pause` high for 5 cycles mid-WASH with 2 ticks left:
  - `stage` stays 2 and `motor`=0 throughout the pause;
  - after release, 2 more WASH cycles, then DRAIN.
- `lid`=0 during SPIN → `spin` and `output_drain` go to 0 and SPIN is held. `start` with `lid`=0 in IDLE → stays in IDLE.
- `reset` asserted in RINSE → all outputs 0 immediately; a new `start` begins again from FILL with `phase`=0.
